// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer and its decoder.
package ctrl_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, MEM} state_t;

  localparam logic [3:0] OP_JMP  = 4'h0;
  localparam logic [3:0] OP_BR1  = 4'h1;
  localparam logic [3:0] OP_BR2  = 4'h2;
  localparam logic [3:0] OP_BR3  = 4'h3;
  localparam logic [3:0] OP_BR4  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_MOVF = 4'hA;
  localparam logic [3:0] OP_NOP  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_LSL  = 4'hD;
  localparam logic [3:0] OP_MOVI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_XOR  = 2;
  localparam int ALU_LSL  = 3;
  localparam int ALU_PASS = 4;

  typedef struct packed {
    logic uncond_jmp;
    logic jtype;
    logic itype;
    logic rd_mem;
    logic wr_mem;
    logic reg_write;
    logic movf;
    logic is_halt;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction register to control bundle plus legality flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic [OPW-1:0]  ir,
  output ctrl_t           ctl,
  output logic [ALUW-1:0] alu_op,
  output logic            legal
);

  logic [3:0] op;

  assign op    = ir[3:0];
  // Shifting instead of slicing keeps OPW=4 legal with no upper field at all.
  assign legal = ((ir >> 4) == '0);

  always_comb begin
    ctl    = '0;
    alu_op = ALUW'(ALU_PASS);
    if (legal) begin
      case (op)
        OP_JMP: begin
          ctl.uncond_jmp = 1'b1;
          ctl.jtype      = 1'b1;
        end
        OP_BR1, OP_BR2, OP_BR3, OP_BR4: ctl.jtype = 1'b1;
        OP_ADD: begin
          ctl.reg_write = 1'b1;
          alu_op        = ALUW'(ALU_ADD);
        end
        OP_XOR: begin
          ctl.reg_write = 1'b1;
          alu_op        = ALUW'(ALU_XOR);
        end
        OP_STR: ctl.wr_mem = 1'b1;
        // ld writes back only when the memory acknowledges; the sequencer gates it.
        OP_LD: begin
          ctl.rd_mem    = 1'b1;
          ctl.reg_write = 1'b1;
        end
        OP_SUB: begin
          ctl.reg_write = 1'b1;
          alu_op        = ALUW'(ALU_SUB);
        end
        OP_MOVF: begin
          ctl.reg_write = 1'b1;
          ctl.movf      = 1'b1;
        end
        OP_NOP: ;
        OP_CMP: alu_op = ALUW'(ALU_SUB);
        OP_LSL: begin
          ctl.itype     = 1'b1;
          ctl.reg_write = 1'b1;
          alu_op        = ALUW'(ALU_LSL);
        end
        OP_MOVI: begin
          ctl.itype     = 1'b1;
          ctl.reg_write = 1'b1;
        end
        OP_HALT: ctl.is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle FETCH/EXEC/MEM control sequencer with Start/Done handshake and retire counter.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 3,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OPW-1:0]  InstrIn,
  input  logic            MemAck,
  output logic            IRLoad,
  output logic            PCEn,
  output logic            UncondJmp,
  output logic            JType,
  output logic            IType,
  output logic            RdMem,
  output logic            WrMem,
  output logic            RegWrite,
  output logic            Movf,
  output logic [ALUW-1:0] ALUOp,
  output logic            MemReq,
  output logic            Done,
  output logic            IllegalOp,
  output logic [CNTW-1:0] InstrCount
);

  state_t          state, state_n;
  logic [OPW-1:0]  ir;
  ctrl_t           ctl;
  logic [ALUW-1:0] alu_op;
  logic            legal;
  logic            retire;
  logic            is_mem;

  ctrl_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
    .ir     (ir),
    .ctl    (ctl),
    .alu_op (alu_op),
    .legal  (legal)
  );

  assign is_mem = ctl.rd_mem | ctl.wr_mem;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      ir         <= '0;
      InstrCount <= '0;
      Done       <= 1'b0;
      IllegalOp  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && Start) begin
        InstrCount <= '0;
        Done       <= 1'b0;
        IllegalOp  <= 1'b0;
      end
      if (state == FETCH) ir <= InstrIn;
      if (retire && InstrCount != '1) InstrCount <= InstrCount + CNTW'(1);
      if (state == EXEC && ctl.is_halt) Done <= 1'b1;
      if (state == EXEC && !legal) IllegalOp <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    retire    = 1'b0;
    IRLoad    = 1'b0;
    PCEn      = 1'b0;
    UncondJmp = 1'b0;
    JType     = 1'b0;
    IType     = 1'b0;
    RdMem     = 1'b0;
    WrMem     = 1'b0;
    RegWrite  = 1'b0;
    Movf      = 1'b0;
    ALUOp     = '0;
    MemReq    = 1'b0;
    case (state)
      IDLE: if (Start) state_n = FETCH;
      FETCH: begin
        IRLoad  = 1'b1;
        state_n = EXEC;
      end
      EXEC: begin
        UncondJmp = ctl.uncond_jmp;
        JType     = ctl.jtype;
        IType     = ctl.itype;
        Movf      = ctl.movf;
        RdMem     = ctl.rd_mem;
        WrMem     = ctl.wr_mem;
        ALUOp     = alu_op;
        if (is_mem) begin
          MemReq  = 1'b1;
          state_n = MEM;
        end else if (ctl.is_halt) begin
          state_n = IDLE;
        end else begin
          RegWrite = ctl.reg_write;
          PCEn     = 1'b1;
          retire   = 1'b1;
          state_n  = FETCH;
        end
      end
      MEM: begin
        RdMem  = ctl.rd_mem;
        WrMem  = ctl.wr_mem;
        ALUOp  = alu_op;
        MemReq = 1'b1;
        // Retirement and ld write-back happen in the acknowledge cycle itself.
        if (MemAck) begin
          RegWrite = ctl.reg_write;
          PCEn     = 1'b1;
          retire   = 1'b1;
          state_n  = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized bench for ctrl_seq against a cycle-level behavioural model built from the opcode table.
module tb_ctrl_seq;

  localparam int OPW  = 6;
  localparam int ALUW = 3;
  localparam int CNTW = 3;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_EXEC  = 2;
  localparam int P_MEM   = 3;

  logic            Clk = 1'b0;
  logic            Reset, Start, MemAck;
  logic [OPW-1:0]  InstrIn;
  logic            IRLoad, PCEn, UncondJmp, JType, IType, RdMem, WrMem, RegWrite, Movf, MemReq;
  logic [ALUW-1:0] ALUOp;
  logic            Done, IllegalOp;
  logic [CNTW-1:0] InstrCount;

  ctrl_seq #(.OPW(OPW), .ALUW(ALUW), .CNTW(CNTW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .InstrIn    (InstrIn),
    .MemAck     (MemAck),
    .IRLoad     (IRLoad),
    .PCEn       (PCEn),
    .UncondJmp  (UncondJmp),
    .JType      (JType),
    .IType      (IType),
    .RdMem      (RdMem),
    .WrMem      (WrMem),
    .RegWrite   (RegWrite),
    .Movf       (Movf),
    .ALUOp      (ALUOp),
    .MemReq     (MemReq),
    .Done       (Done),
    .IllegalOp  (IllegalOp),
    .InstrCount (InstrCount)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cycle  = 0;

  // Reference model state
  int              m_phase;
  logic [OPW-1:0]  m_ir;
  logic [CNTW-1:0] m_cnt;
  logic            m_done, m_ill;

  // Opcode table: {uncond_jmp, jtype, itype, regwrite, movf, aluop[2:0]}
  logic [7:0] optab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cycle, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [OPW-1:0] rnd_ins();
    return OPW'($urandom);
  endfunction

  // Expected {IRLoad,PCEn,UncondJmp,JType,IType,RdMem,WrMem,RegWrite,Movf,MemReq,ALUOp}
  function automatic logic [12:0] expect_outs(input logic ack);
    logic [12:0] e;
    logic [7:0]  t;
    logic [3:0]  op;
    logic        lgl;
    e   = '0;
    op  = m_ir[3:0];
    lgl = (m_ir < 16);
    t   = lgl ? optab[op] : 8'b0000_0100;
    case (m_phase)
      P_FETCH: e[12] = 1'b1;
      P_EXEC: begin
        e[2:0] = t[2:0];
        e[10]  = t[7];
        e[9]   = t[6];
        e[8]   = t[5];
        e[4]   = t[3];
        if (lgl && op == 4'd8) begin
          e[7] = 1'b1; e[3] = 1'b1;
        end else if (lgl && op == 4'd7) begin
          e[6] = 1'b1; e[3] = 1'b1;
        end else if (!(lgl && op == 4'd15)) begin
          e[11] = 1'b1; e[5] = t[4];
        end
      end
      P_MEM: begin
        e[2:0] = 3'd4;
        e[3]   = 1'b1;
        e[7]   = (op == 4'd8);
        e[6]   = (op == 4'd7);
        if (ack) begin
          e[11] = 1'b1; e[5] = (op == 4'd8);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step(input logic st, input logic [OPW-1:0] ins, input logic ack, input logic rs);
    logic retire;
    retire = 1'b0;
    if (!rs) begin
      m_phase = P_IDLE; m_ir = '0; m_cnt = '0; m_done = 1'b0; m_ill = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (st) begin
          m_phase = P_FETCH; m_cnt = '0; m_done = 1'b0; m_ill = 1'b0;
        end
        P_FETCH: begin
          m_ir = ins; m_phase = P_EXEC;
        end
        P_EXEC: begin
          if (m_ir >= 16) begin
            m_ill = 1'b1; retire = 1'b1;
          end else if (m_ir == 15) begin
            m_done = 1'b1; m_phase = P_IDLE;
          end else if (m_ir == 7 || m_ir == 8) begin
            m_phase = P_MEM;
          end else begin
            retire = 1'b1;
          end
        end
        P_MEM: if (ack) retire = 1'b1;
        default: ;
      endcase
      if (retire) begin
        m_phase = P_FETCH;
        if (int'(m_cnt) < (1 << CNTW) - 1) m_cnt = m_cnt + 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance DUT and model together.
  task automatic cyc(input logic st, input logic [OPW-1:0] ins, input logic ack, input logic rs);
    Start = st; InstrIn = ins; MemAck = ack; Reset = rs;
    #3;
    chk("outs", 32'({IRLoad, PCEn, UncondJmp, JType, IType, RdMem, WrMem, RegWrite, Movf, MemReq, ALUOp}),
        32'(expect_outs(ack)));
    chk("instr_count", 32'(InstrCount), 32'(m_cnt));
    chk("done", 32'(Done), 32'(m_done));
    chk("illegal_op", 32'(IllegalOp), 32'(m_ill));
    @(posedge Clk);
    model_step(st, ins, ack, rs);
    cycle++;
    #1;
  endtask

  task automatic run_op(input logic [OPW-1:0] op, input int dly, input bit noise);
    cyc(noise ? rb() : 1'b0, op, noise ? rb() : 1'b0, 1'b1);
    cyc(noise ? rb() : 1'b0, rnd_ins(), noise ? rb() : 1'b0, 1'b1);
    if (m_phase == P_MEM) begin
      for (int k = 0; k < dly; k++) cyc(noise ? rb() : 1'b0, rnd_ins(), 1'b0, 1'b1);
      cyc(noise ? rb() : 1'b0, rnd_ins(), 1'b1, 1'b1);
    end
  endtask

  function automatic logic [OPW-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return {2'($urandom_range(1, 3)), 4'($urandom)};
    return OPW'($urandom_range(0, 14));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    optab = '{8'b1100_0100, 8'b0100_0100, 8'b0100_0100, 8'b0100_0100,
              8'b0100_0100, 8'b0001_0000, 8'b0001_0010, 8'b0000_0100,
              8'b0000_0100, 8'b0001_0001, 8'b0001_1100, 8'b0000_0100,
              8'b0000_0001, 8'b0011_0011, 8'b0011_0100, 8'b0000_0100};

    // Reset held low two cycles with Start high; first edge brings the DUT out of X.
    Reset = 1'b0; Start = 1'b1; MemAck = 1'b0; InstrIn = '0;
    @(posedge Clk);
    model_step(1'b1, '0, 1'b0, 1'b0);
    #1;
    cyc(1'b1, rnd_ins(), 1'b0, 1'b0);
    cyc(1'b0, rnd_ins(), 1'b0, 1'b1);
    cyc(1'b0, rnd_ins(), 1'b0, 1'b1);
    chk("idle_no_irload", 32'(IRLoad), 32'(0));

    // add then halt
    cyc(1'b1, rnd_ins(), 1'b0, 1'b1);
    run_op(6'h05, 0, 1'b0);
    run_op(6'h0F, 0, 1'b0);
    chk("halt_done", 32'(Done), 32'(1));
    chk("halt_count", 32'(InstrCount), 32'(1));
    cyc(1'b0, rnd_ins(), 1'b0, 1'b1);

    // ld with slow ack, str with immediate ack
    cyc(1'b1, rnd_ins(), 1'b0, 1'b1);
    run_op(6'h08, 2, 1'b0);
    run_op(6'h07, 0, 1'b0);
    run_op(6'h0F, 0, 1'b0);
    chk("mem_count", 32'(InstrCount), 32'(2));

    // cmp, jmp, movi with stray MemAck and Start
    cyc(1'b1, rnd_ins(), 1'b0, 1'b1);
    run_op(6'h0C, 0, 1'b1);
    run_op(6'h00, 0, 1'b1);
    run_op(6'h0E, 0, 1'b1);
    run_op(6'h0F, 0, 1'b0);

    // illegal opcode, sticky flag, cleared by Start; then reset during MEM of a ld
    cyc(1'b1, rnd_ins(), 1'b0, 1'b1);
    run_op(6'b010101, 0, 1'b0);
    chk("illegal_set", 32'(IllegalOp), 32'(1));
    run_op(6'h05, 0, 1'b0);
    run_op(6'h0F, 0, 1'b0);
    chk("illegal_sticky", 32'(IllegalOp), 32'(1));
    cyc(1'b1, rnd_ins(), 1'b0, 1'b1);
    chk("illegal_clr", 32'(IllegalOp), 32'(0));
    cyc(1'b0, 6'h08, 1'b0, 1'b1);
    cyc(1'b0, rnd_ins(), 1'b0, 1'b1);
    cyc(1'b0, rnd_ins(), 1'b0, 1'b1);
    cyc(1'b0, rnd_ins(), 1'b0, 1'b0);
    chk("abort_memreq", 32'(MemReq), 32'(0));
    cyc(1'b0, rnd_ins(), 1'b1, 1'b1);

    // saturation at 7 with mid-program Start pulses
    cyc(1'b1, rnd_ins(), 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) run_op(6'h05, 0, 1'b1);
    run_op(6'h0F, 0, 1'b0);
    chk("sat_count", 32'(InstrCount), 32'(7));
    cyc(1'b1, rnd_ins(), 1'b0, 1'b1);
    chk("restart_count", 32'(InstrCount), 32'(0));
    chk("restart_done", 32'(Done), 32'(0));
    run_op(6'h0F, 0, 1'b0);

    // randomized programs
    for (int p = 0; p < 25; p++) begin
      cyc(1'b1, rnd_ins(), rb(), 1'b1);
      for (int i = 0; i < int'($urandom_range(1, 10)); i++)
        run_op(rnd_op(), int'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 9) == 0) cyc(rb(), rnd_ins(), 1'b0, 1'b0);
      else run_op(6'h0F, 0, 1'b1);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) cyc(1'b0, rnd_ins(), rb(), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
